// File: rtl/set_index_encoder_pkg.sv
// set_index_encoder_pkg: cache-wide set geometry and the walk FSM state encoding.
package set_index_encoder_pkg;
    localparam int NUM_SETS  = 128;
    localparam int SET_IDX_W = 7;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/set_index_encoder_lsb.sv
// lsb_encoder_128to7: combinational lowest-set-bit encoder; idx is 0 when the vector is empty.
module lsb_encoder_128to7
    import set_index_encoder_pkg::*;
#(
    parameter int N = NUM_SETS,
    parameter int W = SET_IDX_W
) (
    input  logic [N-1:0] vector,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (vector[i]) idx = W'(i);
    end
    assign any = |vector;
endmodule

// File: rtl/set_index_encoder.sv
// set_index_encoder: walks a per-set bit vector and emits set indices lowest-first,
// one per valid/ready handshake, with a one-cycle done pulse at the end of a walk.
module set_index_encoder
    import set_index_encoder_pkg::*;
#(
    parameter int NUM_SETS = set_index_encoder_pkg::NUM_SETS,
    parameter int IDX_W    = SET_IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [NUM_SETS-1:0] mask_in,
    input  logic                abort,
    output logic                idx_valid,
    input  logic                idx_ready,
    output logic [IDX_W-1:0]    idx,
    output logic                idx_last,
    output logic [IDX_W:0]      remaining,
    output logic                busy,
    output logic                done
);
    state_t              r_state, w_next;
    logic [NUM_SETS-1:0] r_mask, w_mask, w_mask_rest;
    logic [IDX_W:0]      r_cnt, w_cnt, w_pop;
    logic                w_any, w_hs;

    lsb_encoder_128to7 #(.N(NUM_SETS), .W(IDX_W)) u_lsb (
        .vector (r_mask),
        .idx    (idx),
        .any    (w_any)
    );

    // Clearing the lowest set bit also tells us whether it was the last one.
    assign w_mask_rest = r_mask & (r_mask - NUM_SETS'(1));
    assign idx_valid   = (r_state == ST_SCAN) & w_any;
    assign idx_last    = idx_valid & ~|w_mask_rest;
    assign w_hs        = idx_valid & idx_ready;
    assign remaining   = r_cnt;
    assign busy        = r_state != ST_IDLE;
    assign done        = r_state == ST_DONE;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_SETS; i++)
            w_pop = w_pop + (IDX_W + 1)'(mask_in[i]);
    end

    always_comb begin
        w_next = r_state;
        w_mask = r_mask;
        w_cnt  = r_cnt;
        if (abort) begin
            w_next = ST_IDLE;
            w_mask = '0;
            w_cnt  = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: if (load) begin
                    w_next = |mask_in ? ST_SCAN : ST_DONE;
                    w_mask = mask_in;
                    w_cnt  = w_pop;
                end
                ST_SCAN: if (w_hs) begin
                    w_next = idx_last ? ST_DONE : ST_SCAN;
                    w_mask = w_mask_rest;
                    w_cnt  = r_cnt - 1'b1;
                end
                ST_DONE: w_next = ST_IDLE;
                default: begin
                    w_next = ST_IDLE;
                    w_mask = '0;
                    w_cnt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_mask  <= w_mask;
            r_cnt   <= w_cnt;
        end
    end
endmodule

// File: tb/tb_set_index_encoder.sv
// tb_set_index_encoder: randomized walks against a queue-based reference model;
// a negedge monitor compares every presented index with the front of the expected queue.
module tb_set_index_encoder;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [127:0] mask_in = '0;
    logic         abort = 1'b0;
    logic         idx_ready = 1'b0;
    logic         idx_valid, idx_last, busy, done;
    logic [6:0]   idx;
    logic [7:0]   remaining;

    typedef struct {int idx; int last; int rem;} exp_t;
    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;

    set_index_encoder dut (
        .clk(clk), .rst(rst), .load(load), .mask_in(mask_in), .abort(abort),
        .idx_valid(idx_valid), .idx_ready(idx_ready), .idx(idx), .idx_last(idx_last),
        .remaining(remaining), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream: every set bit in ascending order, remaining counting down to 1.
    task automatic push_model(input logic [127:0] m);
        int r = 0;
        for (int i = 0; i < 128; i++) r += int'(m[i]);
        for (int i = 0; i < 128; i++)
            if (m[i]) begin
                exp_q.push_back('{idx: i, last: int'(r == 1), rem: r});
                r--;
            end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_valid"}, int'(idx_valid), 0);
        chk({name, "_idx"}, int'(idx), 0);
        chk({name, "_last"}, int'(idx_last), 0);
        chk({name, "_rem"}, int'(remaining), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
    endtask

    // Entered and left at 1ns after a rising edge.
    task automatic walk(input logic [127:0] m, input int ready_pct);
        int k = 0;
        int cycles = 0;
        for (int i = 0; i < 128; i++) k += int'(m[i]);
        push_model(m);
        load = 1'b1;
        mask_in = m;
        @(posedge clk); #1;
        load = 1'b0;
        mask_in = ~m;
        if (k > 0) chk("load_rem", int'(remaining), k);
        while (!done && cycles < 2000) begin
            idx_ready = ($urandom_range(99) < ready_pct);
            @(posedge clk); #1;
            cycles++;
        end
        if (!done) chk("done_timeout", cycles, -1);
        else begin
            chk("done_busy", int'(busy), 1);
            chk("done_valid", int'(idx_valid), 0);
            if (ready_pct >= 100) chk("walk_cycles", cycles, k);
        end
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        idx_ready = 1'b0;
        @(posedge clk); #1;
        chk("done_pulse_end", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && idx_valid) begin
            if (exp_q.size() == 0) chk("unexpected_idx", int'(idx), -1);
            else begin
                chk("idx", int'(idx), exp_q[0].idx);
                chk("idx_last", int'(idx_last), exp_q[0].last);
                chk("remaining", int'(remaining), exp_q[0].rem);
                if (idx_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [127:0] m;
        #2 chk_idle("reset_async");
        repeat (2) @(posedge clk);
        #1 chk_idle("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        walk('0, 100);
        m = '0; m[0] = 1'b1; m[5] = 1'b1; m[127] = 1'b1;
        walk(m, 100);
        m = '0; m[64] = 1'b1;
        push_model(m);
        load = 1'b1; mask_in = m;
        @(posedge clk); #1;
        load = 1'b0; idx_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("hold_idx", int'(idx), 64);
            chk("hold_last", int'(idx_last), 1);
            @(posedge clk); #1;
        end
        idx_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_done", int'(done), 1);
        idx_ready = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        walk('1, 100);
        m = '0; m[3] = 1'b1; m[9] = 1'b1; m[20] = 1'b1;
        push_model(m);
        load = 1'b1; mask_in = m;
        @(posedge clk); #1;
        load = 1'b0; idx_ready = 1'b1;
        @(posedge clk); #1;
        idx_ready = 1'b0; load = 1'b1; mask_in = 128'h1;
        @(posedge clk); #1;
        load = 1'b0;
        chk("ignored_load_idx", int'(idx), 9);
        chk("ignored_load_rem", int'(remaining), 2);
        abort = 1'b1; idx_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; idx_ready = 1'b0;
        exp_q.delete();
        chk_idle("abort");
        @(posedge clk); #1;
        chk("abort_no_done", int'(done), 0);
        m = '0; m[10] = 1'b1; m[11] = 1'b1;
        push_model(m);
        load = 1'b1; mask_in = m;
        @(posedge clk); #1;
        load = 1'b0;
        #2 rst = 1'b1;
        #1 chk_idle("midwalk_rst");
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_done", int'(done), 0);
        walk(128'h2, 100);
        for (int t = 0; t < 20; t++) begin
            m = {$urandom, $urandom, $urandom, $urandom};
            if (t % 2 == 0) m &= {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
            walk(m, (t % 3 == 0) ? 100 : int'($urandom_range(30, 90)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
